// File: rtl/fpu_arb_pkg.sv
// ---------------------------------------------------------------------------
// fpu_arb_pkg
// Shared definitions for the two-requester FPU arbiter: the controller state
// encoding, the FPU opcode constants and the default watchdog limit.
// ---------------------------------------------------------------------------
package fpu_arb_pkg;

    // Controller states of the arbiter FSM.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESPOND   = 3'd4
    } arb_state_t;

    // Opcodes understood by the shared FPU; 2'b10 and 2'b11 are rejected.
    localparam logic [1:0] FP_OP_ADD = 2'b00;
    localparam logic [1:0] FP_OP_MUL = 2'b01;

    // Default watchdog limit in clock cycles.
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    // True when the opcode can be forwarded to the FPU.
    function automatic logic op_is_legal(input logic [1:0] opc);
        return (opc == FP_OP_ADD) || (opc == FP_OP_MUL);
    endfunction

endpackage

// File: rtl/fpu_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// fpu_arb_rr_pick
// Combinational round-robin picker for two requesters.
//   req    in  2  request levels, bit i is requester i
//   last   in  1  index of the requester served most recently
//   winner out 1  index of the requester to serve next
//   found  out 1  high when at least one requester is asking
// ---------------------------------------------------------------------------
module fpu_arb_rr_pick
    import fpu_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       found
);

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        found  = |req;
        winner = 1'b0;
        unique case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_arbiter
// Shares one multi-cycle FPU between two requesters. A request is granted in
// IDLE, its opcode/operands are frozen into the FPU drive registers, the FPU
// is started with a start/done handshake, and the result is returned with a
// one-cycle resp_valid pulse on the granted requester's bit.
//
// Optional build macro: FPU_ARB_TIMEOUT_EN adds a watchdog that aborts an
// FPU operation after TIMEOUT_CYCLES cycles with resp_err=1, result=0.
//
// Ports:
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous, active-low reset
//   req            in   2   request level per requester
//   op             in   4   op[2i+1:2i] opcode of requester i
//   a, b           in  64   [32i+31:32i] operands of requester i
//   resp_valid     out  2   one-cycle completion pulse per requester
//   result         out 32   result, valid with resp_valid
//   resp_err       out  1   error flag, valid with resp_valid
//   busy           out  1   high whenever the FSM is not in IDLE
//   grant_id       out  1   requester currently served
//   fpu_start      out  1   FPU start level
//   fpu_operation  out  2   FPU opcode
//   fpu_a, fpu_b   out 32   FPU operands
//   fpu_done       in   1   FPU idle/finished level
//   fpu_result     in  32   FPU output
// ---------------------------------------------------------------------------
module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [3:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [1:0]  resp_valid,
    output logic [31:0] result,
    output logic        resp_err,
    output logic        busy,
    output logic        grant_id,
    output logic        fpu_start,
    output logic [1:0]  fpu_operation,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result
);

    arb_state_t  state, state_nxt;
    logic        last_served, last_served_nxt;
    logic [1:0]  resp_valid_nxt;
    logic [31:0] result_nxt;
    logic        resp_err_nxt;
    logic        busy_nxt;
    logic        grant_id_nxt;
    logic        fpu_start_nxt;
    logic [1:0]  fpu_operation_nxt;
    logic [31:0] fpu_a_nxt, fpu_b_nxt;

    logic        winner;
    logic        found;
    logic [1:0]  sel_op;
    logic [31:0] sel_a, sel_b;
    logic        timed_out;
    logic        in_wait;

    fpu_arb_rr_pick u_pick (
        .req    (req),
        .last   (last_served),
        .winner (winner),
        .found  (found)
    );

    // Fields of the requester the picker would grant this cycle.
    assign sel_op  = op[{winner, 1'b0} +: 2];
    assign sel_a   = a[{winner, 5'b00000} +: 32];
    assign sel_b   = b[{winner, 5'b00000} +: 32];
    assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;

    // Watchdog counts every cycle spent waiting on the FPU and restarts
    // from zero whenever the FSM leaves the wait states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wd_cnt <= '0;
        else if (in_wait)
            wd_cnt <= wd_cnt + CNT_W'(1);
        else
            wd_cnt <= '0;
    end

    assign timed_out = in_wait && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    // State and output registers. Reset leaves the last-served pointer at 1
    // so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last_served   <= 1'b1;
            resp_valid    <= 2'b00;
            result        <= '0;
            resp_err      <= 1'b0;
            busy          <= 1'b0;
            grant_id      <= 1'b0;
            fpu_start     <= 1'b0;
            fpu_operation <= 2'b00;
            fpu_a         <= '0;
            fpu_b         <= '0;
        end else begin
            state         <= state_nxt;
            last_served   <= last_served_nxt;
            resp_valid    <= resp_valid_nxt;
            result        <= result_nxt;
            resp_err      <= resp_err_nxt;
            busy          <= busy_nxt;
            grant_id      <= grant_id_nxt;
            fpu_start     <= fpu_start_nxt;
            fpu_operation <= fpu_operation_nxt;
            fpu_a         <= fpu_a_nxt;
            fpu_b         <= fpu_b_nxt;
        end
    end

    // Next-state logic. Illegal opcodes skip the FPU entirely; in WAIT_DONE
    // a real completion takes priority over a watchdog expiry.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (found && fpu_done)
                    state_nxt = op_is_legal(sel_op) ? ISSUE : RESPOND;
            end
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (timed_out || !fpu_done)
                    state_nxt = timed_out ? RESPOND : WAIT_DONE;
            end
            WAIT_DONE: begin
                if (fpu_done || timed_out)
                    state_nxt = RESPOND;
            end
            RESPOND:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs. Everything holds by default
    // except resp_valid, which is only raised on the edge into RESPOND.
    always_comb begin
        last_served_nxt   = last_served;
        resp_valid_nxt    = 2'b00;
        result_nxt        = result;
        resp_err_nxt      = resp_err;
        grant_id_nxt      = grant_id;
        fpu_start_nxt     = fpu_start;
        fpu_operation_nxt = fpu_operation;
        fpu_a_nxt         = fpu_a;
        fpu_b_nxt         = fpu_b;
        unique case (state)
            IDLE: begin
                if (found && fpu_done) begin
                    grant_id_nxt      = winner;
                    fpu_operation_nxt = sel_op;
                    fpu_a_nxt         = sel_a;
                    fpu_b_nxt         = sel_b;
                    if (!op_is_legal(sel_op)) begin
                        result_nxt     = '0;
                        resp_err_nxt   = 1'b1;
                        resp_valid_nxt = winner ? 2'b10 : 2'b01;
                    end
                end
            end
            ISSUE: fpu_start_nxt = 1'b1;
            WAIT_BUSY: begin
                if (timed_out) begin
                    fpu_start_nxt  = 1'b0;
                    result_nxt     = '0;
                    resp_err_nxt   = 1'b1;
                    resp_valid_nxt = grant_id ? 2'b10 : 2'b01;
                end else if (!fpu_done) begin
                    fpu_start_nxt = 1'b0;
                end
            end
            WAIT_DONE: begin
                if (fpu_done) begin
                    result_nxt     = fpu_result;
                    resp_err_nxt   = 1'b0;
                    resp_valid_nxt = grant_id ? 2'b10 : 2'b01;
                end else if (timed_out) begin
                    fpu_start_nxt  = 1'b0;
                    result_nxt     = '0;
                    resp_err_nxt   = 1'b1;
                    resp_valid_nxt = grant_id ? 2'b10 : 2'b01;
                end
            end
            RESPOND: last_served_nxt = grant_id;
            default: ;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule
